// File: rtl/crtc_timing_sequencer.sv
// Programmable CRTC timing: horizontal/vertical phase FSMs fed by shadowed config registers.
// Optional macro CRTC_VBLANK_IRQ_EN adds irq_ack input and a sticky vblank_irq output.
module crtc_timing_sequencer #(
   parameter int HWIDTH = 11,
   parameter int VWIDTH = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_addr,
   input  logic [15:0]       cfg_data,
`ifdef CRTC_VBLANK_IRQ_EN
   input  logic              irq_ack,
   output logic              vblank_irq,
`endif
   output logic [HWIDTH-1:0] pixel_x,
   output logic [VWIDTH-1:0] line_y,
   output logic              display_en,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start
);

   typedef enum logic [1:0] {ACT = 2'd0, FP = 2'd1, SYNC = 2'd2, BP = 2'd3} phase_t;

   // Index order matches phase_t: [0]=ACT, [1]=FP, [2]=SYNC, [3]=BP.
   localparam logic [3:0][HWIDTH-1:0] H_DEFAULT =
      {HWIDTH'(48), HWIDTH'(96), HWIDTH'(16), HWIDTH'(640)};
   localparam logic [3:0][VWIDTH-1:0] V_DEFAULT =
      {VWIDTH'(33), VWIDTH'(2), VWIDTH'(10), VWIDTH'(480)};

   logic [3:0][HWIDTH-1:0] h_shadow, h_shadow_nxt, h_live;
   logic [3:0][VWIDTH-1:0] v_shadow, v_shadow_nxt, v_live;

   phase_t              hstate, hstate_nxt, vstate, vstate_nxt;
   logic [HWIDTH-1:0]   hcnt, hcnt_nxt;
   logic [VWIDTH-1:0]   vcnt, vcnt_nxt;

   logic [HWIDTH-1:0]   h_len;
   logic [VWIDTH-1:0]   v_len;
   logic                h_last, v_last, line_end, frame_end, load_live, run;
   logic                unused_cfg;

   function automatic logic [HWIDTH-1:0] h_len_fix(input logic [HWIDTH-1:0] d);
      return (d == '0) ? HWIDTH'(1) : d;
   endfunction

   function automatic logic [VWIDTH-1:0] v_len_fix(input logic [VWIDTH-1:0] d);
      return (d == '0) ? VWIDTH'(1) : d;
   endfunction

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         ACT:     return FP;
         FP:      return SYNC;
         SYNC:    return BP;
         default: return ACT;
      endcase
   endfunction

   assign unused_cfg = ^cfg_data;

   // Post-write shadow view; the live copy takes this so a write on the copy clk is included.
   always_comb begin
      h_shadow_nxt = h_shadow;
      v_shadow_nxt = v_shadow;
      if (cfg_we) begin
         if (!cfg_addr[2])
            h_shadow_nxt[cfg_addr[1:0]] = h_len_fix(cfg_data[HWIDTH-1:0]);
         else
            v_shadow_nxt[cfg_addr[1:0]] = v_len_fix(cfg_data[VWIDTH-1:0]);
      end
   end

   assign h_len     = h_live[hstate];
   assign v_len     = v_live[vstate];
   assign h_last    = (hcnt == h_len - HWIDTH'(1));
   assign v_last    = (vcnt == v_len - VWIDTH'(1));
   assign line_end  = (hstate == BP) && h_last;
   assign frame_end = line_end && (vstate == BP) && v_last;
   assign load_live = !enable || frame_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_shadow <= H_DEFAULT;
         v_shadow <= V_DEFAULT;
         h_live   <= H_DEFAULT;
         v_live   <= V_DEFAULT;
      end else begin
         h_shadow <= h_shadow_nxt;
         v_shadow <= v_shadow_nxt;
         if (load_live) begin
            h_live <= h_shadow_nxt;
            v_live <= v_shadow_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hstate <= ACT;
         vstate <= ACT;
         hcnt   <= '0;
         vcnt   <= '0;
      end else begin
         hstate <= hstate_nxt;
         vstate <= vstate_nxt;
         hcnt   <= hcnt_nxt;
         vcnt   <= vcnt_nxt;
      end
   end

   always_comb begin
      hstate_nxt = hstate;
      vstate_nxt = vstate;
      hcnt_nxt   = hcnt;
      vcnt_nxt   = vcnt;
      if (!enable) begin
         hstate_nxt = ACT;
         vstate_nxt = ACT;
         hcnt_nxt   = '0;
         vcnt_nxt   = '0;
      end else begin
         if (h_last) begin
            hstate_nxt = next_phase(hstate);
            hcnt_nxt   = '0;
         end else begin
            hcnt_nxt   = hcnt + HWIDTH'(1);
         end
         // Vertical moves only on the last clk of a line, so vsync lines up with line_start.
         if (line_end) begin
            if (v_last) begin
               vstate_nxt = next_phase(vstate);
               vcnt_nxt   = '0;
            end else begin
               vcnt_nxt   = vcnt + VWIDTH'(1);
            end
         end
      end
   end

`ifdef CRTC_VBLANK_IRQ_EN
   logic vblank_set;
   assign vblank_set = enable && line_end && (vstate == ACT) && v_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vblank_irq <= 1'b0;
      else if (vblank_set)
         vblank_irq <= 1'b1;
      else if (irq_ack)
         vblank_irq <= 1'b0;
   end
`endif

   // Outputs decode registered state directly; reset is included so they read 0 while it is held.
   assign run         = enable && !reset;
   assign pixel_x     = (run && hstate == ACT) ? hcnt : '0;
   assign line_y      = (run && vstate == ACT) ? vcnt : '0;
   assign display_en  = run && (hstate == ACT) && (vstate == ACT);
   assign hsync       = run && (hstate == SYNC);
   assign vsync       = run && (vstate == SYNC);
   assign line_start  = run && (hstate == ACT) && (hcnt == '0);
   assign frame_start = line_start && (vstate == ACT) && (vcnt == '0);

endmodule

// File: tb/tb_crtc_timing_sequencer.sv
// Scoreboard bench for crtc_timing_sequencer: a position-based frame model predicts each clk's outputs.
// Define CRTC_VBLANK_IRQ_EN to also check vblank_irq / irq_ack.
module tb_crtc_timing_sequencer;
   localparam int HW = 11;
   localparam int VW = 10;

   logic          clk = 1'b0;
   logic          reset, enable, cfg_we;
   logic [2:0]    cfg_addr;
   logic [15:0]   cfg_data;
   logic [HW-1:0] pixel_x;
   logic [VW-1:0] line_y;
   logic          display_en, hsync, vsync, line_start, frame_start;
`ifdef CRTC_VBLANK_IRQ_EN
   logic          irq_ack, vblank_irq;
`endif

   always #5 clk = ~clk;

   crtc_timing_sequencer #(.HWIDTH(HW), .VWIDTH(VW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef CRTC_VBLANK_IRQ_EN
      .irq_ack(irq_ack), .vblank_irq(vblank_irq),
`endif
      .pixel_x(pixel_x), .line_y(line_y), .display_en(display_en),
      .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
   );

   typedef struct {
      int px, ly, de, hs, vs, ls, fs, irq, cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Model: live/shadow phase lengths and the position (clk within line, line within frame).
   int   m_h[4], m_v[4], s_h[4], s_v[4];
   int   mx, my;
   bit   m_irq;

   function automatic int phase(int pos, int a, int b, int c);
      if (pos < a) return 0;
      if (pos < a + b) return 1;
      if (pos < a + b + c) return 2;
      return 3;
   endfunction

   function automatic int line_len();
      return m_h[0] + m_h[1] + m_h[2] + m_h[3];
   endfunction

   function automatic int frame_len();
      return m_v[0] + m_v[1] + m_v[2] + m_v[3];
   endfunction

   task automatic model_reset();
      s_h = '{640, 16, 96, 48};
      s_v = '{480, 10, 2, 33};
      m_h = s_h;
      m_v = s_v;
      mx = 0;
      my = 0;
      m_irq = 1'b0;
   endtask

   task automatic step(input bit rst, input bit e, input bit we, input int addr, input int data,
                       input bit ack);
      exp_t x;
      int   hp, vp, ll, fl, v;
      bit   fe;
      @(posedge clk);
      #1;
      reset    = rst;
      enable   = e;
      cfg_we   = we;
      cfg_addr = addr[2:0];
      cfg_data = data[15:0];
`ifdef CRTC_VBLANK_IRQ_EN
      irq_ack  = ack;
`endif
      cyc++;
      if (rst) model_reset();
      x = '{default: 0};
      x.cyc = cyc;
      if (!rst && e) begin
         hp = phase(mx, m_h[0], m_h[1], m_h[2]);
         vp = phase(my, m_v[0], m_v[1], m_v[2]);
         x.px = (hp == 0) ? mx : 0;
         x.ly = (vp == 0) ? my : 0;
         x.de = (hp == 0 && vp == 0) ? 1 : 0;
         x.hs = (hp == 2) ? 1 : 0;
         x.vs = (vp == 2) ? 1 : 0;
         x.ls = (mx == 0) ? 1 : 0;
         x.fs = (mx == 0 && my == 0) ? 1 : 0;
      end
      x.irq = m_irq ? 1 : 0;
      q.push_back(x);
      if (!rst) begin
         if (we) begin
            v = (addr < 4) ? (data & ((1 << HW) - 1)) : (data & ((1 << VW) - 1));
            if (v == 0) v = 1;
            if (addr < 4) s_h[addr] = v;
            else s_v[addr - 4] = v;
         end
         ll = line_len();
         fl = frame_len();
         if (e && mx == ll - 1 && my == m_v[0] - 1) m_irq = 1'b1;
         else if (ack) m_irq = 1'b0;
         if (!e) begin
            mx = 0;
            my = 0;
            m_h = s_h;
            m_v = s_v;
         end else begin
            fe = (mx == ll - 1) && (my == fl - 1);
            mx++;
            if (mx == ll) begin
               mx = 0;
               my++;
               if (my == fl) my = 0;
            end
            if (fe) begin
               m_h = s_h;
               m_v = s_v;
            end
         end
      end
   endtask

   task automatic run(input int n, input bit e);
      for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic wr(input int addr, input int data, input bit e);
      step(1'b0, e, 1'b1, addr, data, 1'b0);
   endtask

   task automatic chk(input string nm, input int act, input int exp, input int c);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, c, act, exp);
      end
   endtask

   // Monitor: pops one expectation per clk and compares away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pixel_x", int'(pixel_x), e.px, e.cyc);
            chk("line_y", int'(line_y), e.ly, e.cyc);
            chk("display_en", int'(display_en), e.de, e.cyc);
            chk("hsync", int'(hsync), e.hs, e.cyc);
            chk("vsync", int'(vsync), e.vs, e.cyc);
            chk("line_start", int'(line_start), e.ls, e.cyc);
            chk("frame_start", int'(frame_start), e.fs, e.cyc);
`ifdef CRTC_VBLANK_IRQ_EN
            chk("vblank_irq", int'(vblank_irq), e.irq, e.cyc);
`endif
         end
      end
   end

   initial begin
      int  guard;
      bit  we_r, e_r, ack_r;
      reset = 1'b1;
      enable = 1'b0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
`ifdef CRTC_VBLANK_IRQ_EN
      irq_ack = 1'b0;
`endif
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

      // Defaults: a few 800-clk lines with hsync at 656..751.
      run(2500, 1'b1);
      run(1, 1'b0);

      // Small config H 4/1/2/1, V 3/1/1/1 written while idle.
      wr(0, 4, 1'b0); wr(1, 1, 1'b0); wr(2, 2, 1'b0); wr(3, 1, 1'b0);
      wr(4, 3, 1'b0); wr(5, 1, 1'b0); wr(6, 1, 1'b0); wr(7, 1, 1'b0);
      run(150, 1'b1);

      // Mid-frame H_ACT change takes effect at the next frame.
      run(13, 1'b1);
      wr(0, 6, 1'b1);
      run(150, 1'b1);
      wr(0, 4, 1'b1);
      run(100, 1'b1);

      // Zero H_SYNC is stored as 1.
      wr(2, 0, 1'b1);
      run(120, 1'b1);

      // Write exactly on the frame-end clk.
      guard = 0;
      while (!(mx == line_len() - 1 && my == frame_len() - 1) && guard < 1000) begin
         run(1, 1'b1);
         guard++;
      end
      chk("frame_end_reached", guard < 1000 ? 1 : 0, 1, cyc);
      wr(3, 3, 1'b1);
      run(120, 1'b1);

      // Drop enable mid-line for 3 clks.
      run(3, 1'b1);
      run(3, 1'b0);
      run(60, 1'b1);

      // IRQ ack exercise, then randomized traffic.
      for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 0, 0, (i % 37) == 0);
      for (int i = 0; i < 20000; i++) begin
         e_r   = ($urandom_range(0, 199) != 0);
         we_r  = ($urandom_range(0, 49) == 0);
         ack_r = ($urandom_range(0, 9) == 0);
         step(1'b0, e_r, we_r, int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), ack_r);
      end

      // Asynchronous reset mid-run, then defaults again.
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      run(900, 1'b1);

      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0, cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
